// File: rtl/rng_pkg.sv
// rng_pkg: shared types and constants for the game RNG arbiter
package rng_pkg;
  typedef enum logic [1:0] {IDLE, SEED, RUN} state_t;
  localparam int REQ_PIPE = 0;
  localparam int REQ_COIN = 1;
  localparam int LFSR_W = 8;
endpackage

// File: rtl/lfsr8.sv
// lfsr8: 8-bit game LFSR, loadable with a seed and stepped on demand
module lfsr8
  import rng_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] out
);
  // load wins over stepping; without en the register holds its value
  always_ff @(posedge clk)
    if (rst) out <= '0;
    else if (load) out <= seed;
    else if (en) out <= {out[6], out[5] ^ out[7], out[4] ^ out[7], out[3] ^ out[7], out[2], out[1], out[0], out[7]};
endmodule

// File: rtl/rng_arbiter.sv
// rng_arbiter: seeds and runs the game LFSR and round-robins mapped values to two requesters (FIXED_SEED_EN selects a constant seed)
module rng_arbiter
  import rng_pkg::*;
#(
  parameter logic [7:0] GAP_MIN    = 8'd40,
  parameter logic [7:0] GAP_SPAN   = 8'd160,
  parameter logic [7:0] FIXED_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       halt,
  input  logic [1:0] req,
  output logic [1:0] ack,
  output logic [7:0] value,
  output logic       ready
);
  state_t            state, state_nx;
  logic [7:0]        cnt, seed_reg, new_seed, mapped;
  logic [LFSR_W-1:0] raw;
  logic [1:0]        grant;
  logic              ptr;
`ifdef FIXED_SEED_EN
  assign new_seed = FIXED_SEED;
`else
  assign new_seed = (cnt == 8'h00) ? 8'h01 : cnt;
`endif
  lfsr8 u_lfsr (
    .clk (clk),
    .rst (rst),
    .load(state == SEED),
    .en  (state == RUN),
    .seed(seed_reg),
    .out (raw)
  );
  // next state, grant selection and range mapping; halt suppresses any grant
  always_comb begin
    state_nx = (state == IDLE) ? (start ? SEED : IDLE) : (state == SEED) ? RUN : (halt ? IDLE : RUN);
    grant    = (state != RUN || halt) ? 2'b00 : (req == 2'b11) ? (ptr ? 2'b01 : 2'b10) : req;
    mapped   = GAP_MIN + ((raw >= GAP_SPAN) ? raw - GAP_SPAN : raw);
  end
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // free-running seed counter, seed capture, grant pulse, held value and tie pointer
  always_ff @(posedge clk)
    if (rst) begin
      cnt      <= 8'h00;
      seed_reg <= 8'h00;
      ptr      <= 1'b1;
      ack      <= 2'b00;
      value    <= 8'h00;
    end else begin
      cnt <= cnt + 8'h01;
      if (state == IDLE && start) seed_reg <= new_seed;
      ack <= grant;
      if (|grant) value <= mapped;
      if (&req && |grant) ptr <= grant[REQ_COIN];
    end
  assign ready = (state == RUN);
endmodule
